// File: rtl/seg7_hex_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg7_hex_decoder
// Purpose  : Readback monitor. It recovers hex nibbles from a multiplexed
//            active-low 7-segment bus, once each pattern has been stable.
//            Optional macro SEG7_ERR_CNT_EN adds err_count/err_clr.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg_in,
    input  logic [2:0]              dig_sel,
    input  logic                    sample_en,
`ifdef SEG7_ERR_CNT_EN
    input  logic                    err_clr,
    output logic [7:0]              err_count,
`endif
    output logic [4*NUM_DIGITS-1:0] data_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    upd,
    output logic [2:0]              upd_digit,
    output logic                    err
);

    localparam int               CNT_W        = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_STABLE     = STABLE_CYCLES[CNT_W-1:0];
    localparam logic [3:0]       c_NUM_DIG    = NUM_DIGITS[3:0];

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_QUALIFY = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t                  r_state, w_next;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                    r_smp_en;
    logic [2:0]              r_sel, r_prev_sel;
    logic [6:0]              r_seg, r_prev_seg;
    logic                    w_qual, w_same, w_accept;
    logic [3:0]              w_nib;
    logic                    w_legal, w_blank;
    logic [4*NUM_DIGITS-1:0] r_data;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic                    r_upd, r_err;
    logic [2:0]              r_upd_digit;

    assign w_qual    = r_smp_en && ({1'b0, r_sel} < c_NUM_DIG);
    assign w_same    = (r_sel == r_prev_sel) && (r_seg == r_prev_seg);
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_smp_en   <= 1'b0;
            r_sel      <= 3'd0;
            r_seg      <= 7'd0;
            r_prev_sel <= 3'd0;
            r_prev_seg <= 7'd0;
            r_state    <= S_IDLE;
            r_cnt      <= '0;
        end else begin
            r_smp_en   <= sample_en;
            r_sel      <= dig_sel;
            r_seg      <= seg_in;
            r_prev_sel <= r_sel;
            r_prev_seg <= r_seg;
            r_state    <= w_next;
            r_cnt      <= w_cnt_nxt;
        end
    end

    // A new pattern always restarts at count 1; with STABLE_CYCLES==1 that
    // first sample is already enough to accept.
    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        w_accept  = 1'b0;
        if (!w_qual) begin
            w_next    = S_IDLE;
            w_cnt_nxt = '0;
        end else if (r_state == S_IDLE || !w_same) begin
            w_cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
            if (c_STABLE == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                w_accept = 1'b1;
                w_next   = S_LOCKED;
            end else begin
                w_next   = S_QUALIFY;
            end
        end else if (r_state == S_QUALIFY) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == c_STABLE) begin
                w_accept = 1'b1;
                w_next   = S_LOCKED;
            end
        end
    end

    always_comb begin
        w_nib   = 4'h0;
        w_legal = 1'b1;
        w_blank = 1'b0;
        case (r_seg)
            7'h40:   w_nib = 4'h0;
            7'h79:   w_nib = 4'h1;
            7'h24:   w_nib = 4'h2;
            7'h30:   w_nib = 4'h3;
            7'h19:   w_nib = 4'h4;
            7'h12:   w_nib = 4'h5;
            7'h02:   w_nib = 4'h6;
            7'h78:   w_nib = 4'h7;
            7'h00:   w_nib = 4'h8;
            7'h10:   w_nib = 4'h9;
            7'h08:   w_nib = 4'hA;
            7'h03:   w_nib = 4'hB;
            7'h46:   w_nib = 4'hC;
            7'h21:   w_nib = 4'hD;
            7'h06:   w_nib = 4'hE;
            7'h0E:   w_nib = 4'hF;
            7'h7F: begin
                w_legal = 1'b0;
                w_blank = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data      <= '0;
            r_valid     <= '0;
            r_upd       <= 1'b0;
            r_err       <= 1'b0;
            r_upd_digit <= 3'd0;
        end else begin
            r_upd <= 1'b0;
            r_err <= 1'b0;
            if (w_accept) begin
                r_upd_digit <= r_sel;
                r_upd       <= w_legal || w_blank;
                r_err       <= !(w_legal || w_blank);
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (r_sel == 3'(i)) begin
                        if (w_legal) begin
                            r_data[4*i +: 4] <= w_nib;
                            r_valid[i]       <= 1'b1;
                        end else if (w_blank) begin
                            r_valid[i]       <= 1'b0;
                        end
                    end
                end
            end
        end
    end

`ifdef SEG7_ERR_CNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= 8'd0;
        end else if (err_clr) begin
            r_err_count <= 8'd0;
        end else if (w_accept && !w_legal && !w_blank && r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign data_out    = r_data;
    assign digit_valid = r_valid;
    assign upd         = r_upd;
    assign err         = r_err;
    assign upd_digit   = r_upd_digit;

endmodule
`default_nettype wire

// File: tb/tb_seg7_hex_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg7_hex_decoder
// Purpose  : Directed vector bench for seg7_hex_decoder (NUM_DIGITS=6,
//            STABLE_CYCLES=4); covers SEG7_ERR_CNT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_hex_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  seg_in = 7'h7F;
    logic [2:0]  dig_sel = 3'd0;
    logic        sample_en = 1'b0;
    logic [23:0] data_out;
    logic [5:0]  digit_valid;
    logic        upd, err;
    logic [2:0]  upd_digit;
`ifdef SEG7_ERR_CNT_EN
    logic        err_clr = 1'b0;
    logic [7:0]  err_count;
`endif

    seg7_hex_decoder #(.NUM_DIGITS(6), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .sample_en   (sample_en),
`ifdef SEG7_ERR_CNT_EN
        .err_clr     (err_clr),
        .err_count   (err_count),
`endif
        .data_out    (data_out),
        .digit_valid (digit_valid),
        .upd         (upd),
        .upd_digit   (upd_digit),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] dig;
        logic [6:0] seg;
        int         n;
        int         e_upd;
        int         e_err;
        logic [3:0] nib;
        logic [1:0] act;   // 0 none, 1 write nibble, 2 blank
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          upd_seen = 0;
    int          err_seen = 0;
    logic [2:0]  last_dig = 3'd0;
    logic [23:0] m_data = '0;
    logic [5:0]  m_valid = '0;
    vec_t        vt[21];
    logic [6:0]  codes[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        if (upd) begin
            upd_seen++;
            last_dig = upd_digit;
        end
        if (err) begin
            err_seen++;
            last_dig = upd_digit;
        end
    endtask

    task automatic drive(input logic [2:0] d, input logic [6:0] s, input logic en);
        dig_sel   = d;
        seg_in    = s;
        sample_en = en;
    endtask

    task automatic hold(input logic [2:0] d, input logic [6:0] s, input int n);
        drive(d, s, 1'b1);
        repeat (n) cyc();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_data"}, {8'h0, data_out}, {8'h0, m_data});
        check({tag, "_valid"}, {26'h0, digit_valid}, {26'h0, m_valid});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int u0, e0, first;

        for (int i = 0; i < 16; i++)
            vt[i] = '{3'd0, codes[i], 6, 1, 0, 4'(i), 2'd1};
        vt[16] = '{3'd0, 7'h10, 6, 1, 0, 4'h9, 2'd1};
        vt[17] = '{3'd0, 7'h7F, 6, 1, 0, 4'h0, 2'd2};
        vt[18] = '{3'd1, 7'h0E, 3, 0, 0, 4'h0, 2'd0};
        vt[19] = '{3'd1, 7'h06, 1, 0, 0, 4'h0, 2'd0};
        vt[20] = '{3'd1, 7'h0E, 6, 1, 0, 4'hF, 2'd1};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_data", {8'h0, data_out}, 32'h0);
        check("rst_valid", {26'h0, digit_valid}, 32'h0);
        check("rst_upd", {31'h0, upd}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_upd_digit", {29'h0, upd_digit}, 32'h0);
`ifdef SEG7_ERR_CNT_EN
        check("rst_err_count", {24'h0, err_count}, 32'h0);
`endif
        reset_n = 1'b1;

        // Exact acceptance latency on digit 2
        u0 = upd_seen;
        first = 0;
        drive(3'd2, 7'h24, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (first == 0 && upd_seen != u0) first = i;
        end
        m_data[11:8] = 4'h2;
        m_valid[2]   = 1'b1;
        check("lat_edge", first, 5);
        check("lat_count", upd_seen - u0, 1);
        check("lat_digit", {29'h0, last_dig}, 2);
        check_state("lat");

        // Sweep, blank and glitch vectors
        for (int k = 0; k < 21; k++) begin
            u0 = upd_seen;
            e0 = err_seen;
            hold(vt[k].dig, vt[k].seg, vt[k].n);
            if (vt[k].act == 2'd1) begin
                m_data[vt[k].dig*4 +: 4] = vt[k].nib;
                m_valid[vt[k].dig]       = 1'b1;
            end else if (vt[k].act == 2'd2) begin
                m_valid[vt[k].dig] = 1'b0;
            end
            check($sformatf("v%0d_upd", k), upd_seen - u0, vt[k].e_upd);
            check($sformatf("v%0d_err", k), err_seen - e0, vt[k].e_err);
            if (vt[k].e_upd != 0)
                check($sformatf("v%0d_dig", k), {29'h0, last_dig}, {29'h0, vt[k].dig});
            check_state($sformatf("v%0d", k));
        end

        // Illegal pattern on digit 3
        u0 = upd_seen;
        e0 = err_seen;
        hold(3'd3, 7'h7E, 6);
        check("ill_err", err_seen - e0, 1);
        check("ill_upd", upd_seen - u0, 0);
        check("ill_digit", {29'h0, last_dig}, 3);
        check_state("ill");
`ifdef SEG7_ERR_CNT_EN
        check("errcnt_one", {24'h0, err_count}, 1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("errcnt_clr", {24'h0, err_count}, 0);
`endif

        // Reset in the middle of qualification
        hold(3'd5, 7'h40, 2);
        reset_n = 1'b0;
        #1;
        check("mrst_data", {8'h0, data_out}, 32'h0);
        check("mrst_valid", {26'h0, digit_valid}, 32'h0);
        check("mrst_upd", {31'h0, upd}, 32'h0);
        check("mrst_err", {31'h0, err}, 32'h0);
        check("mrst_upd_digit", {29'h0, upd_digit}, 32'h0);
        m_data  = '0;
        m_valid = '0;
        repeat (2) cyc();
        reset_n = 1'b1;
        u0 = upd_seen;
        repeat (4) cyc();
        check("mrst_early", upd_seen - u0, 0);
        cyc();
        check("mrst_upd_cnt", upd_seen - u0, 1);
        check("mrst_upd_dig", {29'h0, last_dig}, 5);
        m_valid[5] = 1'b1;
        check_state("mrst");

        // Unqualified samples change nothing
        u0 = upd_seen;
        e0 = err_seen;
        drive(3'd4, 7'h24, 1'b0);
        repeat (20) cyc();
        drive(3'd7, 7'h24, 1'b1);
        repeat (20) cyc();
        check("idle_upd", upd_seen - u0, 0);
        check("idle_err", err_seen - e0, 0);
        check_state("idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_hex_decoder.md
Name: seg7_hex_decoder

Overview:
- Inverse of the team's hex-to-7-segment display encoder: observes active-low 7-segment patterns on a multiplexed display bus and recovers the 4-bit hex value for each digit.
- Sits beside the display driver as a self-check/readback monitor, or on an external multiplexed display input.
- Patterns must be stable for a programmable number of cycles before acceptance.
- Maintains a per-digit register bank with valid flags, update pulses and error reporting.

Parameters:
- NUM_DIGITS, 6, number of multiplexed digits tracked (2..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- seg_in  in  7  active-low segments, bit0=a .. bit6=g.
- dig_sel  in  3  digit index currently driven on seg_in.
- sample_en  in  1  1 = seg_in/dig_sel meaningful this cycle.
- data_out  out  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i].
- digit_valid  out  NUM_DIGITS  1 = digit i holds a decoded hex value.
- upd  out  1  one-cycle pulse: a digit was written or blanked.
- upd_digit  out  3  digit index for the current upd/err pulse.
- err  out  1  one-cycle pulse: a stable pattern is not a legal code.

Behaviour:
- Reset (async assert, sync release): data_out=0, digit_valid=0, upd=0, upd_digit=0, err=0, FSM=IDLE, counter=0, input register=0.
- Input stage: {sample_en, dig_sel, seg_in} registered every edge.
  - A sample is qualified only if sample_en=1 and dig_sel<NUM_DIGITS.
  - dig_sel>=NUM_DIGITS counts as sample_en=0.
- FSM states:
  - IDLE: on a qualified sample, load counter=1 and go to QUALIFY.
  - QUALIFY: if the sample is qualified and equals the previous registered {dig_sel, seg_in}, increment counter. A different qualified sample reloads counter=1 and stays in QUALIFY. An unqualified sample goes to IDLE with counter=0. When counter reaches STABLE_CYCLES, perform acceptance and go to LOCKED.
  - LOCKED: hold; no writes and no pulses. Any change or unqualified sample is handled exactly as in QUALIFY, restarting qualification.
- Acceptance:
  - Legal codes, as hex value:pattern for 0..F: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E.
  - Legal code: write the nibble to digit dig_sel, set digit_valid[dig_sel]=1, pulse upd.
  - Blank (7F): clear digit_valid[dig_sel], leave the nibble unchanged, pulse upd.
  - Any other pattern: pulse err. The data and valid flags are untouched.
  - upd_digit=dig_sel for the upd or err pulse. upd and err are never high together.
- Latency:
  - Inputs constant and qualified at edges E1..E(STABLE_CYCLES) are registered one edge later.
  - data_out, digit_valid, upd and err update at edge E(STABLE_CYCLES+1).
  - upd and err deassert on the following edge.
- Re-acceptance:
  - The same pattern held indefinitely is accepted once only (LOCKED).
  - Leaving and returning, even for one cycle, re-qualifies the pattern and produces a new pulse.
- Mid-operation: reset_n low clears everything immediately, including the partial count. The first qualified sample after release starts from IDLE.
- Digits not currently selected keep their stored values indefinitely.

Optional Feature:
- Macro: SEG7_ERR_CNT_EN.
- Defined: adds output err_count (8 bits).
  - Increments on each err pulse and saturates at 255.
  - Reset to 0 by reset_n.
  - Cleared synchronously by an added input err_clr (1 bit). err_clr has priority over increment on the same edge.
- Undefined: no err_count or err_clr ports and no counter logic. All other behaviour is identical.

Test Plan:
- Reset then hold dig_sel=2, seg_in=24, sample_en=1 for 10 cycles (STABLE_CYCLES=4):
  - One upd pulse exactly 5 edges after the first sampling edge, with upd_digit=2.
  - data_out[11:8]=2, digit_valid=000100.
  - No further pulses.
- Sweep digit 0 through all 16 legal codes, each held 6 cycles:
  - 16 upd pulses.
  - data_out[3:0] tracks 0..F; digit_valid[0]=1 throughout.
- Glitch: dig_sel=1, seg_in=0E for 3 cycles, then 06 for 1 cycle, then 0E for 6 cycles:
  - No pulse during the first 4 cycles.
  - A single upd after the final qualification; data_out[7:4]=F.
- Illegal pattern 7E held 6 cycles on digit 3:
  - One err pulse with upd_digit=3; data_out and digit_valid unchanged.
  - With SEG7_ERR_CNT_EN: err_count goes 0->1, and err_clr returns it to 0.
- Blank 7F on digit 0 after value 9:
  - digit_valid[0] falls to 0 with a upd pulse; data_out[3:0] stays 9.
- Assert reset_n=0 after 2 of 4 stable cycles, release, then hold 40 on digit 5 for 5 stable cycles:
  - All outputs are 0 during reset.
  - Exactly one upd after a full 4-cycle qualification from release; data_out[23:20]=0, digit_valid[5]=1.
- Additional check with sample_en=0 or dig_sel=7 (NUM_DIGITS=6) for 20 cycles: no upd, no err, state unchanged.
